// File: rtl/store_buffer.sv
// store_buffer: circular store FIFO; retired stores drain in order to the tbus arbiter
// Ports: clock/reset_n (async active-low); enq_* store from memory stage;
//        commit_valid retires the oldest uncommitted store; flush_* discards younger uncommitted stores;
//        sb2arb_tbus_* write request/handshake toward the arbiter; fwd_* load forwarding; sb_empty.
// Build option: define STORE_BUFFER_FWD_EN for store-to-load forwarding (fwd_* tie to 0 otherwise).
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 6
`endif
`ifndef TBUS_OPTYPE_RANGE
`define TBUS_OPTYPE_RANGE 1:0
`endif
`ifndef TBUS_OP_WRITE
`define TBUS_OP_WRITE 2'b01
`endif

module store_buffer #(
    parameter int SB_DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [63:0]               enq_addr,
    input  logic [63:0]               enq_data,
    input  logic [63:0]               enq_mask,
    input  logic                      enq_robidx_flag,
    input  logic [`ROB_SIZE_LOG-1:0]  enq_robidx,
    input  logic                      commit_valid,
    input  logic                      flush_valid,
    input  logic                      flush_robidx_flag,
    input  logic [`ROB_SIZE_LOG-1:0]  flush_robidx,
    output logic                      sb2arb_tbus_index_valid,
    input  logic                      sb2arb_tbus_index_ready,
    output logic [63:0]               sb2arb_tbus_index,
    output logic [63:0]               sb2arb_tbus_write_data,
    output logic [63:0]               sb2arb_tbus_write_mask,
    input  logic                      sb2arb_tbus_operation_done,
    output logic [`TBUS_OPTYPE_RANGE] sb2arb_tbus_operation_type,
    input  logic [63:0]               fwd_addr,
    output logic                      fwd_hit,
    output logic [63:0]               fwd_data,
    output logic [63:0]               fwd_mask,
    output logic                      sb_empty
);
    localparam int IW = $clog2(SB_DEPTH);
    localparam int PW = IW + 1;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state;
    logic [PW-1:0] head, cmt, tail, cmt_nx, pend, tail_flush;
    logic [63:0] addr_q [SB_DEPTH];
    logic [63:0] data_q [SB_DEPTH];
    logic [63:0] mask_q [SB_DEPTH];
    logic flag_q [SB_DEPTH];
    logic [`ROB_SIZE_LOG-1:0] rob_q [SB_DEPTH];
    logic do_enq;

    // head..cmt are committed, cmt..tail are speculative
    assign enq_ready = !((head[IW] != tail[IW]) && (head[IW-1:0] == tail[IW-1:0]));
    assign sb_empty = head == tail;
    assign do_enq = enq_valid && enq_ready && !flush_valid;
    assign cmt_nx = cmt + PW'(commit_valid && cmt != tail);
    assign pend = tail - cmt_nx;
    assign sb2arb_tbus_operation_type = `TBUS_OP_WRITE;

    function automatic logic younger(input logic [IW-1:0] i);
        return (flush_robidx_flag ^ flag_q[i]) ^ (flush_robidx < rob_q[i]);
    endfunction

    // Commit is applied first, so only entries past the advanced commit pointer may be discarded;
    // scanning downward leaves the oldest discarded slot as the new tail.
    always_comb begin
        tail_flush = tail;
        for (int i = SB_DEPTH - 1; i >= 0; i--)
            if (PW'(i) < pend && younger(cmt_nx[IW-1:0] + IW'(i)))
                tail_flush = cmt_nx + PW'(i);
    end

    always_ff @(posedge clock)
        if (do_enq) begin
            addr_q[tail[IW-1:0]] <= enq_addr;
            data_q[tail[IW-1:0]] <= enq_data;
            mask_q[tail[IW-1:0]] <= enq_mask;
            flag_q[tail[IW-1:0]] <= enq_robidx_flag;
            rob_q[tail[IW-1:0]] <= enq_robidx;
        end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            head <= '0;
            cmt <= '0;
            tail <= '0;
            state <= IDLE;
            sb2arb_tbus_index_valid <= 1'b0;
            sb2arb_tbus_index <= '0;
            sb2arb_tbus_write_data <= '0;
            sb2arb_tbus_write_mask <= '0;
        end else begin
            cmt <= cmt_nx;
            tail <= flush_valid ? tail_flush : tail + PW'(do_enq);
            case (state)
                IDLE: if (head != cmt) begin
                    state <= REQ;
                    sb2arb_tbus_index_valid <= 1'b1;
                    sb2arb_tbus_index <= addr_q[head[IW-1:0]];
                    sb2arb_tbus_write_data <= data_q[head[IW-1:0]];
                    sb2arb_tbus_write_mask <= mask_q[head[IW-1:0]];
                end
                REQ: if (sb2arb_tbus_index_ready) begin
                    state <= WAIT;
                    sb2arb_tbus_index_valid <= 1'b0;
                end
                WAIT: if (sb2arb_tbus_operation_done) begin
                    state <= IDLE;
                    head <= head + PW'(1);
                end
                default: state <= IDLE;
            endcase
        end

`ifdef STORE_BUFFER_FWD_EN
    logic [PW-1:0] count;
    logic [IW-1:0] k;
    logic unused_fwd;
    assign count = tail - head;
    assign unused_fwd = ^fwd_addr[2:0];
    // oldest to youngest, so younger stores overwrite the lanes they cover
    always_comb begin
        fwd_data = '0;
        fwd_mask = '0;
        k = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            k = head[IW-1:0] + IW'(i);
            if (PW'(i) < count && addr_q[k][63:3] == fwd_addr[63:3]) begin
                fwd_data = (fwd_data & ~mask_q[k]) | (data_q[k] & mask_q[k]);
                fwd_mask = fwd_mask | mask_q[k];
            end
        end
    end
    assign fwd_hit = |fwd_mask;
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_addr;
    assign fwd_hit = 1'b0;
    assign fwd_data = '0;
    assign fwd_mask = '0;
`endif
endmodule
